// File: rtl/change_payout_ctrl_if.sv
// Payout request and coin-ejector handshake bundle for change_payout_ctrl.
interface change_payout_ctrl_if #(
  parameter int AMT_W = 6
);
  logic             pay_req;
  logic [AMT_W-1:0] pay_amt;
  logic             eject_ack;
  logic             eject_req;
  logic [1:0]       eject_sel;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;

  // Requester / ejector side
  modport master (
    output pay_req, pay_amt, eject_ack,
    input  eject_req, eject_sel, busy, done, short, remaining
  );

  // Payout controller side
  modport slave (
    input  pay_req, pay_amt, eject_ack,
    output eject_req, eject_sel, busy, done, short, remaining
  );
endinterface

// File: rtl/change_payout_ctrl.sv
// Greedy change payout sequencer for three coin tubes (5, 10, 20 units).
// One coin per four-phase handshake with the ejector; tracks tube stock,
// accepts refill pulses and reports any amount left unpaid.
module change_payout_ctrl #(
  parameter int CNT_W   = 4,
  parameter int AMT_W   = 6,
  parameter int INIT_5  = 10,
  parameter int INIT_10 = 10,
  parameter int INIT_20 = 10
) (
  input  logic             clk,
  input  logic             reset,
  change_payout_ctrl_if.slave bus,
  input  logic             refill_5,
  input  logic             refill_10,
  input  logic             refill_20,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_20
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    EJECT   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_5    = 2'b01;
  localparam logic [1:0] SEL_10   = 2'b10;
  localparam logic [1:0] SEL_20   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Value in units of the coin encoded by sel.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
    logic [AMT_W-1:0] v;
    case (sel)
      SEL_5:   v = AMT_W'(5);
      SEL_10:  v = AMT_W'(10);
      SEL_20:  v = AMT_W'(20);
      default: v = AMT_W'(0);
    endcase
    return v;
  endfunction

  // Tube stock update: refill saturates, refill plus eject cancel out.
  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] n;
    if (inc && dec) begin
      n = cnt;
    end else if (inc) begin
      n = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    end else if (dec) begin
      n = (cnt == CNT_ZERO) ? CNT_ZERO : cnt - CNT_W'(1);
    end else begin
      n = cnt;
    end
    return n;
  endfunction

  state_t           state_r, state_nxt;
  logic [1:0]       sel_r, sel_nxt;
  logic [AMT_W-1:0] rem_r;
  logic             short_r, short_nxt;
  logic             load_s, take_s;
  logic             eject_req_r, busy_r, done_r;
  logic [1:0]       eject_sel_r;
  logic [CNT_W-1:0] cnt_5_r, cnt_10_r, cnt_20_r;

  // Next-state, coin choice and datapath strobes for the payout FSM.
  always_comb begin
    state_nxt = state_r;
    sel_nxt   = sel_r;
    short_nxt = short_r;
    load_s    = 1'b0;
    take_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.pay_req) begin
          load_s    = 1'b1;
          short_nxt = 1'b0;
          state_nxt = SELECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SELECT: begin
        if (rem_r >= AMT_W'(20) && cnt_20_r != CNT_ZERO) begin
          sel_nxt   = SEL_20;
          state_nxt = EJECT;
        end else if (rem_r >= AMT_W'(10) && cnt_10_r != CNT_ZERO) begin
          sel_nxt   = SEL_10;
          state_nxt = EJECT;
        end else if (rem_r >= AMT_W'(5) && cnt_5_r != CNT_ZERO) begin
          sel_nxt   = SEL_5;
          state_nxt = EJECT;
        end else if (rem_r == AMT_W'(0)) begin
          short_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          short_nxt = 1'b1;
          state_nxt = DONE;
        end
      end
      EJECT: begin
        if (bus.eject_ack) begin
          take_s    = 1'b1;
          state_nxt = RELEASE;
        end else begin
          state_nxt = EJECT;
        end
      end
      RELEASE: begin
        if (!bus.eject_ack) begin
          state_nxt = SELECT;
        end else begin
          state_nxt = RELEASE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, chosen coin, remaining amount and short flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      sel_r   <= SEL_NONE;
      rem_r   <= AMT_W'(0);
      short_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      sel_r   <= sel_nxt;
      short_r <= short_nxt;
      if (load_s) begin
        rem_r <= bus.pay_amt;
      end else if (take_s) begin
        rem_r <= rem_r - coin_value(sel_r);
      end else begin
        rem_r <= rem_r;
      end
    end
  end

  // Registered outputs derived from the upcoming state, so eject_req has no path from eject_ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eject_req_r <= 1'b0;
      eject_sel_r <= SEL_NONE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      eject_req_r <= (state_nxt == EJECT);
      eject_sel_r <= (state_nxt == EJECT) ? sel_nxt : SEL_NONE;
      busy_r      <= (state_nxt != IDLE);
      done_r      <= (state_nxt == DONE);
    end
  end

  // Tube stock counters: refills in any state, one decrement per acknowledged coin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_5_r  <= CNT_W'(INIT_5);
      cnt_10_r <= CNT_W'(INIT_10);
      cnt_20_r <= CNT_W'(INIT_20);
    end else begin
      cnt_5_r  <= next_count(cnt_5_r,  refill_5,  take_s && sel_r == SEL_5);
      cnt_10_r <= next_count(cnt_10_r, refill_10, take_s && sel_r == SEL_10);
      cnt_20_r <= next_count(cnt_20_r, refill_20, take_s && sel_r == SEL_20);
    end
  end

  assign bus.eject_req = eject_req_r;
  assign bus.eject_sel = eject_sel_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.short     = short_r;
  assign bus.remaining = rem_r;
  assign cnt_5         = cnt_5_r;
  assign cnt_10        = cnt_10_r;
  assign cnt_20        = cnt_20_r;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Self-checking bench for change_payout_ctrl: directed cases plus randomized
// payouts and refills against a greedy arithmetic reference model.
module tb_change_payout_ctrl;
  localparam int CNT_W = 4;
  localparam int AMT_W = 6;
  localparam int CMAX  = 15;

  logic clk;
  logic reset;
  logic refill_5, refill_10, refill_20;
  logic [CNT_W-1:0] cnt_5, cnt_10, cnt_20;

  change_payout_ctrl_if #(.AMT_W(AMT_W)) bus ();

  change_payout_ctrl #(
    .CNT_W(CNT_W), .AMT_W(AMT_W), .INIT_5(10), .INIT_10(10), .INIT_20(10)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .refill_5(refill_5), .refill_10(refill_10), .refill_20(refill_20),
    .cnt_5(cnt_5), .cnt_10(cnt_10), .cnt_20(cnt_20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m5, m10, m20;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_cnt5"},  int'(cnt_5),  m5);
    check_eq({tag, "_cnt10"}, int'(cnt_10), m10);
    check_eq({tag, "_cnt20"}, int'(cnt_20), m20);
  endtask

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // One payout. Expected coin sequence is computed up front: as many 20s as
  // fit and are stocked, then 10s, then 5s. ack_refill20 pulses refill_20 on
  // the first coin's ack; extra_req fires a second pay_req while busy.
  task automatic run_pay(input int amt, input bit ack_refill20, input bit extra_req);
    int coins[$];
    int r, n, idx, cycles, exp_rem;
    bit got_done, exp_short;
    r = amt;
    n = (r / 20 < m20) ? r / 20 : m20;
    for (int i = 0; i < n; i++) coins.push_back(3);
    r -= 20 * n; m20 -= n;
    n = (r / 10 < m10) ? r / 10 : m10;
    for (int i = 0; i < n; i++) coins.push_back(2);
    r -= 10 * n; m10 -= n;
    n = (r / 5 < m5) ? r / 5 : m5;
    for (int i = 0; i < n; i++) coins.push_back(1);
    r -= 5 * n; m5 -= n;
    exp_rem   = r;
    exp_short = (r != 0);

    @(negedge clk);
    bus.pay_req = 1'b1;
    bus.pay_amt = AMT_W'(amt);
    @(negedge clk);
    bus.pay_req = 1'b0;
    check_eq("busy_after_req", int'(bus.busy), 1);

    idx = 0; cycles = 0; got_done = 1'b0;
    @(negedge clk);
    while (!got_done && cycles < 300) begin
      if (bus.done) begin
        got_done = 1'b1;
      end else if (bus.eject_req) begin
        if (idx < coins.size()) check_eq("eject_sel", int'(bus.eject_sel), coins[idx]);
        else check_eq("extra_eject", idx, coins.size());
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_eq("req_held", int'(bus.eject_req), 1);
        bus.eject_ack = 1'b1;
        if (ack_refill20 && idx == 0) begin
          refill_20 = 1'b1;
          m20 = (coins.size() > 0 && coins[0] == 3) ? m20 + 1 : sat_inc(m20);
        end
        if (extra_req && idx == 0) begin
          bus.pay_req = 1'b1;
          bus.pay_amt = ~AMT_W'(amt);
        end
        @(negedge clk);
        refill_20   = 1'b0;
        bus.pay_req = 1'b0;
        check_eq("req_drop_on_ack", int'(bus.eject_req), 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.eject_ack = 1'b0;
        idx++;
      end
      if (!got_done) begin
        @(negedge clk);
        cycles++;
      end
    end
    check_eq("done_seen", int'(got_done), 1);
    check_eq("eject_count", idx, coins.size());
    if (coins.size() == 0) check_eq("done_latency", cycles, 0);
    check_eq("short", int'(bus.short), int'(exp_short));
    check_eq("remaining", int'(bus.remaining), exp_rem);
    check_counts("pay");
    @(negedge clk);
    check_eq("done_one_cycle", int'(bus.done), 0);
    check_eq("idle_after_done", int'(bus.busy), 0);
  endtask

  task automatic random_refills();
    bit a, b, c;
    a = 1'($urandom_range(0, 1));
    b = 1'($urandom_range(0, 1));
    c = 1'($urandom_range(0, 1));
    @(negedge clk);
    refill_5 = a; refill_10 = b; refill_20 = c;
    if (a) m5  = sat_inc(m5);
    if (b) m10 = sat_inc(m10);
    if (c) m20 = sat_inc(m20);
    @(negedge clk);
    refill_5 = 1'b0; refill_10 = 1'b0; refill_20 = 1'b0;
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    refill_5 = 1'b0; refill_10 = 1'b0; refill_20 = 1'b0;
    bus.pay_req = 1'b0; bus.pay_amt = '0; bus.eject_ack = 1'b0;
    m5 = 10; m10 = 10; m20 = 10;
    repeat (2) @(negedge clk);
    check_eq("rst_eject_req", int'(bus.eject_req), 0);
    check_eq("rst_eject_sel", int'(bus.eject_sel), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_short", int'(bus.short), 0);
    check_eq("rst_remaining", int'(bus.remaining), 0);
    check_counts("rst");
    reset = 1'b0;

    // Full tubes, pay 35: 20, 10, 5.
    run_pay(35, 1'b0, 1'b0);
    check_counts("pay35");
    // Not a multiple of 5.
    run_pay(7, 1'b0, 1'b0);
    // Zero amount.
    run_pay(0, 1'b0, 1'b0);
    // Refill of the 20 tube on the 20-coin ack; second request while busy.
    run_pay(45, 1'b1, 1'b1);

    // Saturation of all three tubes.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      refill_5 = 1'b1; refill_10 = 1'b1; refill_20 = 1'b1;
      m5 = sat_inc(m5); m10 = sat_inc(m10); m20 = sat_inc(m20);
    end
    @(negedge clk);
    refill_5 = 1'b0; refill_10 = 1'b0; refill_20 = 1'b0;
    check_counts("saturate");
    check_eq("sat_value", int'(cnt_5), CMAX);

    // Reset in the middle of an eject.
    @(negedge clk);
    bus.pay_req = 1'b1; bus.pay_amt = AMT_W'(25);
    @(negedge clk);
    bus.pay_req = 1'b0;
    waited = 0;
    while (!bus.eject_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("mid_wait_req", int'(bus.eject_req), 1);
    #2 reset = 1'b1;
    #1;
    m5 = 10; m10 = 10; m20 = 10;
    check_eq("mid_rst_req", int'(bus.eject_req), 0);
    check_eq("mid_rst_busy", int'(bus.busy), 0);
    check_eq("mid_rst_rem", int'(bus.remaining), 0);
    check_counts("mid_rst");
    @(negedge clk);
    reset = 1'b0;

    // Randomized payouts with idle-time refills.
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0) random_refills();
      run_pay(int'($urandom_range(0, 63)), 1'b0, 1'b0);
    end

    // Drain every tube, then an empty-machine payout.
    for (int t = 0; t < 30 && (m5 + m10 + m20) > 0; t++) begin
      run_pay(63, 1'b0, 1'b0);
    end
    check_eq("drained", m5 + m10 + m20, 0);
    run_pay(15, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/change_payout_ctrl.md
# change_payout_ctrl

Sequences the payout of change from three coin tubes (5, 10 and 20 units) to the coin-eject mechanism of the cash vending machine. A payout request carries an amount. The block pays it out greedily, largest coin first, one coin per four-phase handshake with the ejector. It tracks the stock in each tube, accepts refill pulses, and reports any amount it could not pay.

## Interface
Parameters:
- CNT_W, 4, width of each tube stock counter; saturates at 2^CNT_W-1
- AMT_W, 6, width of amount and remaining-amount buses
- INIT_5, 10, tube-5 stock after reset
- INIT_10, 10, tube-10 stock after reset
- INIT_20, 10, tube-20 stock after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-high
- pay_req  in  1  one-cycle request pulse; sampled only in IDLE
- pay_amt  in  AMT_W  amount to pay; sampled with pay_req
- refill_5 / refill_10 / refill_20  in  1 each  one-cycle pulse: add one coin to that tube
- eject_ack  in  1  ejector acknowledge (four-phase)
- eject_req  out  1  eject one coin
- eject_sel  out  2  coin being ejected: 01=5, 10=10, 11=20; 00 when eject_req=0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a payout
- short  out  1  the last payout was incomplete; valid from done until the next accepted pay_req
- remaining  out  AMT_W  amount still unpaid
- cnt_5 / cnt_10 / cnt_20  out  CNT_W each  current tube stock

## Operation
- Reset values:
  - state = IDLE
  - eject_req = 0, eject_sel = 00
  - busy = 0, done = 0, short = 0
  - remaining = 0
  - cnt_* = INIT_*
- A reset asserted mid-payout aborts it immediately and drops eject_req asynchronously.
- FSM states: IDLE, SELECT, EJECT, RELEASE, DONE.
- IDLE:
  - pay_req=1 → load remaining=pay_amt, clear short, go to SELECT.
  - pay_req is ignored in every other state; no queuing.
- SELECT picks the first matching rule:
  - remaining≥20 and cnt_20>0 → sel=11, go to EJECT
  - else remaining≥10 and cnt_10>0 → sel=10, go to EJECT
  - else remaining≥5 and cnt_5>0 → sel=01, go to EJECT
  - else remaining==0 → go to DONE, short=0
  - else → go to DONE, short=1. This covers both an empty tube and an amount that is not a multiple of 5.
- EJECT:
  - eject_req=1; eject_sel holds the chosen coin.
  - On the edge where eject_ack=1 is sampled: subtract the coin value from remaining, decrement that tube, drop eject_req, go to RELEASE.
- RELEASE: wait until eject_ack=0 is sampled, then go to SELECT.
- DONE: done=1 for one cycle, then go to IDLE.
- Refills:
  - Accepted in any state.
  - Increment saturates at 2^CNT_W-1.
  - A refill and a decrement on the same tube in the same cycle leave the count unchanged.
- Arithmetic: remaining is unsigned. Subtraction never underflows because each coin is chosen only when remaining ≥ its value.

## Timing
- pay_req sampled at edge k → busy=1 after edge k (state SELECT).
- Edge k+1: SELECT → EJECT; eject_req=1 after edge k+1.
- Ack sampled high at edge m → eject_req=0 and counters updated after edge m.
- Ack sampled low at edge n → SELECT after edge n, EJECT again after edge n+1.
- Minimum cost per coin is 3 cycles, with ack high for 1 cycle and low for 1 cycle.
- pay_amt=0: done after edge k+1 and high for one cycle; IDLE, busy=0 after edge k+2.
- eject_req is a registered output with no combinational path from eject_ack.

## Test plan
- Tubes full (10/10/10), pay 35 → ejects 20, 10, 5 in that order; done, short=0, remaining=0, counts 9/9/9.
- INIT_20=0, pay 40 → four ejects of 10; cnt_10=6, short=0.
- INIT_5=0, INIT_10=0, INIT_20=0, pay 15 → no eject_req; done after 2 cycles with short=1, remaining=15.
- pay 7 → one eject of 5, then done with short=1, remaining=2.
- refill_20 pulsed in the same cycle as ack of a 20-coin → cnt_20 unchanged; a second pay_req while busy → ignored and remaining unaffected.
- reset asserted while eject_req=1 → eject_req=0, busy=0, counts back to INIT_* without waiting for a clock edge.
